// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit
// Registered ALU control unit between instruction decode and the ALU.
// Decodes {alu_op, opcode} into an ALU control word, handshakes with
// valid/ready on both sides, and sequences multi-cycle opcodes by holding
// the control word while busy is high for MC_CYCLES-1 cycles.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   flush                  synchronous flush, returns to IDLE next cycle
//   in_valid / in_ready    upstream handshake
//   alu_op, opcode         op class from main control, instruction opcode
//   alu_ctrl               registered control word (loads only on accept)
//   alu_en                 ALU executes with alu_ctrl this cycle
//   busy                   multi-cycle op in progress
//   out_valid / out_ready  downstream handshake for the completed op
//   illegal                held op was an illegal encoding
//   err_cnt                saturating count of accepted illegal ops
module alu_ctrl_unit #(
  parameter int unsigned                   OPCODE_W  = 4,
  parameter int unsigned                   CNT_W     = 4,
  parameter logic [(2**OPCODE_W)-1:0]      MC_MASK   = 16'hC000,
  parameter int unsigned                   MC_CYCLES = 4,
  parameter int unsigned                   ERR_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          alu_op,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CNT_W-1:0]    alu_ctrl,
  output logic                alu_en,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                illegal,
  output logic [ERR_W-1:0]    err_cnt
);

  // Counter holds remaining MC_RUN cycles after the current one.
  localparam int unsigned    CW        = (MC_CYCLES > 2) ? $clog2(MC_CYCLES - 1) : 1;
  localparam logic [CW-1:0]  CNT_LOAD  = CW'(MC_CYCLES - 2);
  localparam int unsigned    CTRL_SPAN = 2 ** CNT_W;

  typedef enum logic [1:0] {IDLE, MC_RUN, ISSUE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] dec_ctrl;
  logic            dec_ill, dec_mc;
  logic            accept;
  int unsigned     op_u;

  // Decode of the op currently presented upstream.
  always_comb begin
    dec_ctrl = '0;
    dec_ill  = 1'b0;
    dec_mc   = 1'b0;
    op_u     = 32'(opcode);
    unique case (alu_op)
      2'b10: dec_ctrl = '0;
      2'b01: dec_ctrl = CNT_W'(1);
      2'b00: begin
        // Opcodes 0/1 are reserved; 2.. map onto control words 0..
        if (op_u >= 32'd2 && (op_u - 32'd2) < CTRL_SPAN) begin
          dec_ctrl = CNT_W'(op_u - 32'd2);
          dec_mc   = MC_MASK[opcode];
        end else begin
          dec_ill  = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_ready  = !flush && (state_q == IDLE || (state_q == ISSUE && out_ready));
  assign accept    = in_valid && in_ready;
  assign alu_en    = (state_q != IDLE);
  assign busy      = (state_q == MC_RUN);
  assign out_valid = (state_q == ISSUE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = dec_mc ? MC_RUN : ISSUE;
          cnt_d   = dec_mc ? CNT_LOAD : '0;
        end
      end
      MC_RUN: begin
        if (cnt_q == '0) state_d = ISSUE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ISSUE: begin
        if (out_ready) begin
          // Retire and load the next op on the same edge when one is offered.
          if (accept) begin
            state_d = dec_mc ? MC_RUN : ISSUE;
            cnt_d   = dec_mc ? CNT_LOAD : '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      alu_ctrl <= '0;
      illegal  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        alu_ctrl <= dec_ctrl;
        illegal  <= dec_ill;
        if (dec_ill && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
module tb_alu_ctrl_unit;
  localparam int          MC_CYCLES  = 4;
  localparam logic [15:0] TB_MC_MASK = 16'hC000;

  logic       clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [3:0] opcode = 4'd0;
  logic       in_ready, alu_en, busy, out_valid, illegal;
  logic [3:0] alu_ctrl;
  logic [7:0] err_cnt;

  int n_tests = 0, n_fail = 0;

  // Reference model: op pending flag plus cycles left before completion.
  bit m_pend, m_ill;
  int m_rem, m_ctrl, m_err;

  alu_ctrl_unit #(.OPCODE_W(4), .CNT_W(4), .MC_MASK(TB_MC_MASK),
                  .MC_CYCLES(MC_CYCLES), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .alu_op(alu_op), .opcode(opcode), .alu_ctrl(alu_ctrl),
    .alu_en(alu_en), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .illegal(illegal), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  function automatic void ref_decode(input logic [1:0] op, input logic [3:0] oc,
                                     output int c, output bit il, output bit mc);
    int o;
    o = oc; c = 0; il = 0; mc = 0;
    if (op == 2'b01) c = 1;
    else if (op == 2'b11) il = 1;
    else if (op == 2'b00) begin
      if (o >= 2 && o - 2 < 16) begin c = o - 2; mc = TB_MC_MASK[o]; end
      else il = 1;
    end
  endfunction

  function automatic bit m_rdy();
    return !flush && (!m_pend || (m_rem == 0 && out_ready));
  endfunction

  task automatic m_clear();
    m_pend = 0; m_ill = 0; m_rem = 0; m_ctrl = 0; m_err = 0;
  endtask

  // One clock edge; model advances from the inputs seen before the edge.
  task automatic tick();
    int c; bit il, mc, acc;
    acc = in_valid && m_rdy();
    ref_decode(alu_op, opcode, c, il, mc);
    @(posedge clk);
    if (flush) begin m_pend = 0; m_rem = 0; end
    else if (acc) begin
      m_pend = 1; m_rem = mc ? MC_CYCLES - 1 : 0; m_ctrl = c; m_ill = il;
      if (il && m_err < 255) m_err++;
    end
    else if (m_pend && m_rem > 0) m_rem--;
    else if (m_pend && out_ready) m_pend = 0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 0; alu_op = 0; opcode = 0;
    m_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({in_ready, alu_en, busy, out_valid, illegal} !== 5'b10000 || alu_ctrl !== 0 || err_cnt !== 0) begin
      n_fail++; $display("FAIL reset: rdy/en/busy/ov/ill=%b ctrl=%0d err=%0d want 10000 0 0",
        {in_ready, alu_en, busy, out_valid, illegal}, alu_ctrl, err_cnt);
    end
  endtask

  task automatic test_single();
    alu_op = 2'b00; opcode = 4'd5; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    n_tests++;
    if (alu_ctrl !== 4'd3 || out_valid !== 1 || busy !== 0 || illegal !== 0 || alu_en !== 1) begin
      n_fail++; $display("FAIL single: ctrl=%0d ov=%b busy=%b ill=%b en=%b want 3 1 0 0 1",
        alu_ctrl, out_valid, busy, illegal, alu_en);
    end
    out_ready = 1;
    tick();
    n_tests++;
    if (out_valid !== 0 || alu_en !== 0 || alu_ctrl !== 4'd3) begin
      n_fail++; $display("FAIL single_idle: ov=%b en=%b ctrl=%0d want 0 0 3", out_valid, alu_en, alu_ctrl);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    out_ready = 1; alu_op = 2'b00; in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      opcode = 4'(k + 2);
      #1;
      if (in_ready !== 1) bad++;
      tick();
      if (alu_ctrl !== 4'(k) || out_valid !== 1) bad++;
    end
    in_valid = 0;
    tick();
    n_tests++;
    if (bad != 0 || out_valid !== 0) begin
      n_fail++; $display("FAIL back_to_back: %0d bad cycles, final ov=%b want 0 0", bad, out_valid);
    end
  endtask

  task automatic test_multicycle();
    alu_op = 2'b00; opcode = 4'd14; in_valid = 1; out_ready = 1;
    tick();
    opcode = 4'd3; out_ready = 0;
    for (int i = 0; i < MC_CYCLES - 1; i++) begin
      #1;
      n_tests++;
      if (busy !== 1 || alu_en !== 1 || out_valid !== 0 || alu_ctrl !== 4'd12 || in_ready !== 0) begin
        n_fail++; $display("FAIL mc_busy%0d: busy=%b en=%b ov=%b ctrl=%0d rdy=%b want 1 1 0 12 0",
          i, busy, alu_en, out_valid, alu_ctrl, in_ready);
      end
      tick();
    end
    n_tests++;
    if (busy !== 0 || out_valid !== 1 || alu_en !== 1 || alu_ctrl !== 4'd12) begin
      n_fail++; $display("FAIL mc_done: busy=%b ov=%b en=%b ctrl=%0d want 0 1 1 12", busy, out_valid, alu_en, alu_ctrl);
    end
    in_valid = 0; out_ready = 1;
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1; in_valid = 1; alu_op = 2'b11; opcode = 4'd6;
    tick();
    n_tests++;
    if (illegal !== 1 || alu_ctrl !== 0) begin
      n_fail++; $display("FAIL illegal_op11: ill=%b ctrl=%0d want 1 0", illegal, alu_ctrl);
    end
    alu_op = 2'b00; opcode = 4'd1;
    tick();
    in_valid = 0;
    tick();
    n_tests++;
    if (illegal !== 1 || alu_ctrl !== 0 || err_cnt !== 8'd2) begin
      n_fail++; $display("FAIL illegal_opc1: ill=%b ctrl=%0d err=%0d want 1 0 2", illegal, alu_ctrl, err_cnt);
    end
    in_valid = 1; alu_op = 2'b11;
    repeat (300) tick();
    in_valid = 0;
    tick();
    n_tests++;
    if (err_cnt !== 8'd255) begin
      n_fail++; $display("FAIL err_saturate: err=%0d want 255", err_cnt);
    end
  endtask

  task automatic test_flush();
    logic [7:0] e0;
    alu_op = 2'b00; opcode = 4'd14; in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    tick();
    e0 = err_cnt;
    flush = 1; in_valid = 1; alu_op = 2'b11;
    #1;
    n_tests++;
    if (in_ready !== 0 || busy !== 1) begin
      n_fail++; $display("FAIL flush_rdy: rdy=%b busy=%b want 0 1", in_ready, busy);
    end
    tick();
    flush = 0; in_valid = 0;
    n_tests++;
    if (busy !== 0 || out_valid !== 0 || alu_en !== 0 || alu_ctrl !== 4'd12 || err_cnt !== e0 || illegal !== 0) begin
      n_fail++; $display("FAIL flush: busy=%b ov=%b en=%b ctrl=%0d err=%0d ill=%b want 0 0 0 12 %0d 0",
        busy, out_valid, alu_en, alu_ctrl, err_cnt, illegal, e0);
    end
    tick();
    n_tests++;
    if (out_valid !== 0 || in_ready !== 1) begin
      n_fail++; $display("FAIL flush_idle: ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_hold_reset();
    alu_op = 2'b00; opcode = 4'd7; in_valid = 1; out_ready = 0;
    tick();
    opcode = 4'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (in_ready !== 0 || out_valid !== 1 || alu_ctrl !== 4'd5) begin
        n_fail++; $display("FAIL hold%0d: rdy=%b ov=%b ctrl=%0d want 0 1 5", i, in_ready, out_valid, alu_ctrl);
      end
      tick();
    end
    #2 rst_n = 0; in_valid = 0;
    #1;
    n_tests++;
    if ({alu_en, busy, out_valid, illegal} !== 4'b0000 || alu_ctrl !== 0 || err_cnt !== 0) begin
      n_fail++; $display("FAIL async_reset: en/busy/ov/ill=%b ctrl=%0d err=%0d want 0000 0 0",
        {alu_en, busy, out_valid, illegal}, alu_ctrl, err_cnt);
    end
    m_clear();
    @(posedge clk);
    #1 rst_n = 1;
    #1;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      alu_op    = 2'($urandom_range(0, 3));
      opcode    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom_range(0, 15));
      #1;
      if (in_ready !== m_rdy()) bad++;
      tick();
      if (alu_ctrl !== 4'(m_ctrl) || illegal !== m_ill || err_cnt !== 8'(m_err) ||
          alu_en !== m_pend || busy !== (m_pend && m_rem > 0) ||
          out_valid !== (m_pend && m_rem == 0)) begin
        if (bad < 5) $display("FAIL random cyc %0d: ctrl=%0d ill=%b err=%0d en=%b busy=%b ov=%b want %0d %b %0d %b %b %b",
          n, alu_ctrl, illegal, err_cnt, alu_en, busy, out_valid, m_ctrl, m_ill, m_err,
          m_pend, m_pend && m_rem > 0, m_pend && m_rem == 0);
        bad++;
      end
    end
    flush = 0; in_valid = 0;
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL random: %0d mismatching cycles, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_multicycle();
    test_illegal();
    test_flush();
    test_hold_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
